// File: rtl/rotary_value_ctrl_if.sv
// -----------------------------------------------------------------------------
// rotary_value_ctrl_if
// Bundles the signals between a quadrature decoder / host and the rotary value
// controller.
//   master : decoder/host side; drives detent, error and load requests and
//            observes the value and status.
//   slave  : controller side (rotary_value_ctrl).
// Signals:
//   I_CNT, I_CW      detent pulse and its direction (1 = increment)
//   I_ERR            decode-error pulse
//   I_WRAP           1 = wrap at bounds, 0 = saturate
//   I_LOAD, IV_LOAD  load strobe and load value
//   I_ERR_CLR        clears the error counter
//   OV_VALUE         current value
//   O_CHANGED        one-cycle pulse when OV_VALUE changes
//   O_AT_MIN/MAX     value sits on a bound
//   O_FAST, O_LOCKED controller mode
//   OV_ERR_CNT       saturating error count
// -----------------------------------------------------------------------------
interface rotary_value_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             I_CNT;
   logic             I_CW;
   logic             I_ERR;
   logic             I_WRAP;
   logic             I_LOAD;
   logic [WIDTH-1:0] IV_LOAD;
   logic             I_ERR_CLR;
   logic [WIDTH-1:0] OV_VALUE;
   logic             O_CHANGED;
   logic             O_AT_MIN;
   logic             O_AT_MAX;
   logic             O_FAST;
   logic             O_LOCKED;
   logic [3:0]       OV_ERR_CNT;

   modport master (
      output I_CNT, I_CW, I_ERR, I_WRAP, I_LOAD, IV_LOAD, I_ERR_CLR,
      input  OV_VALUE, O_CHANGED, O_AT_MIN, O_AT_MAX, O_FAST, O_LOCKED, OV_ERR_CNT
   );

   modport slave (
      input  I_CNT, I_CW, I_ERR, I_WRAP, I_LOAD, IV_LOAD, I_ERR_CLR,
      output OV_VALUE, O_CHANGED, O_AT_MIN, O_AT_MAX, O_FAST, O_LOCKED, OV_ERR_CNT
   );
endinterface

// File: rtl/rotary_value_ctrl.sv
// -----------------------------------------------------------------------------
// rotary_value_ctrl
// Owns the user-visible value driven by a rotary encoder. Applies bounded or
// wrapping arithmetic per detent, speed-dependent step size (acceleration),
// post-error lockout and keeps a saturating error count. All outputs are
// registered.
// Ports:
//   CLK    system clock
//   RST_N  synchronous reset, active low
//   bus    rotary_value_ctrl_if.slave (detent/error/load inputs, value and
//          status outputs)
// Configuration:
//   ROTARY_VALUE_CTRL_ACCEL_EN  when defined, builds the gap timer, streak
//   counter and FAST state. When undefined every detent uses SLOW_STEP, the
//   FSM has SLOW and LOCK only and O_FAST is tied low.
// -----------------------------------------------------------------------------
module rotary_value_ctrl #(
   parameter int WIDTH       = 8,
   parameter int MIN         = 0,
   parameter int MAX         = 255,
   parameter int INIT        = 0,
   parameter int SLOW_STEP   = 1,
   parameter int FAST_STEP   = 4,
   parameter int FAST_WINDOW = 250000,
   parameter int FAST_COUNT  = 3,
   parameter int LOCK_CYCLES = 125000
) (
   input  logic               CLK,
   input  logic               RST_N,
   rotary_value_ctrl_if.slave bus
);

   // Two extra bits give headroom for value +/- step without overflow and a sign.
   localparam int SW     = WIDTH + 2;
   localparam int RANGE  = MAX - MIN + 1;
   localparam int INIT_C = (INIT < MIN) ? MIN : ((INIT > MAX) ? MAX : INIT);
   localparam int LW     = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES + 1);

   localparam logic [WIDTH-1:0]     MIN_V      = WIDTH'(MIN);
   localparam logic [WIDTH-1:0]     MAX_V      = WIDTH'(MAX);
   localparam logic [WIDTH-1:0]     INIT_V     = WIDTH'(INIT_C);
   localparam logic signed [SW-1:0] MIN_S      = SW'(MIN);
   localparam logic signed [SW-1:0] MAX_S      = SW'(MAX);
   localparam logic signed [SW-1:0] RANGE_S    = SW'(RANGE);
   localparam logic signed [SW-1:0] SLOW_S     = SW'(SLOW_STEP);
   localparam logic signed [SW-1:0] FAST_S     = SW'(FAST_STEP);
   // Steps pre-reduced modulo the range so one correction always lands in range.
   localparam logic signed [SW-1:0] SLOW_MOD_S = SW'(SLOW_STEP % RANGE);
   localparam logic signed [SW-1:0] FAST_MOD_S = SW'(FAST_STEP % RANGE);
   localparam logic [LW-1:0]        LOCK_V     = LW'(LOCK_CYCLES);

   localparam logic [1:0] ST_SLOW = 2'd0;
   localparam logic [1:0] ST_LOCK = 2'd2;
`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
   localparam logic [1:0] ST_FAST = 2'd1;

   localparam int GW  = (FAST_WINDOW < 2) ? 1 : $clog2(FAST_WINDOW + 1);
   localparam int STW = (FAST_COUNT < 2) ? 1 : $clog2(FAST_COUNT + 1);
   localparam logic [GW-1:0]  FW_V = GW'(FAST_WINDOW);
   localparam logic [STW-1:0] FC_V = STW'(FAST_COUNT);
`endif

   function automatic logic [WIDTH-1:0] f_sat(input logic signed [SW-1:0] s);
      logic signed [SW-1:0] r;
      r = s;
      if (s > MAX_S)
         r = MAX_S;
      else if (s < MIN_S)
         r = MIN_S;
      return WIDTH'(r);
   endfunction

   function automatic logic [WIDTH-1:0] f_wrap(input logic signed [SW-1:0] s);
      logic signed [SW-1:0] r;
      r = s;
      if (s > MAX_S)
         r = s - RANGE_S;
      else if (s < MIN_S)
         r = s + RANGE_S;
      return WIDTH'(r);
   endfunction

   function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] v,
                                               input logic             cw,
                                               input logic             wrap,
                                               input logic             fast);
      logic signed [SW-1:0] v_s;
      logic signed [SW-1:0] st_s;
      logic signed [SW-1:0] sum_s;
      v_s = signed'({2'b00, v});
      if (wrap)
         st_s = fast ? FAST_MOD_S : SLOW_MOD_S;
      else
         st_s = fast ? FAST_S : SLOW_S;
      sum_s = cw ? (v_s + st_s) : (v_s - st_s);
      return wrap ? f_wrap(sum_s) : f_sat(sum_s);
   endfunction

   logic [WIDTH-1:0] r_value;
   logic             r_changed;
   logic             r_at_min;
   logic             r_at_max;
   logic [1:0]       r_state;
   logic [LW-1:0]    r_lock_tmr;
   logic [3:0]       r_err_cnt;

   logic [WIDTH-1:0] w_value_nxt;
   logic [1:0]       w_state_nxt;
   logic [LW-1:0]    w_lock_nxt;
   logic [3:0]       w_err_nxt;
   logic             w_use_fast;

`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
   logic [GW-1:0]    r_gap;
   logic [STW-1:0]   r_streak;
   logic             r_dir;
   logic [GW-1:0]    w_gap_nxt;
   logic [STW-1:0]   w_streak_nxt;
   logic             w_dir_nxt;
   logic             w_quick;
`endif

   always_comb begin
      w_value_nxt = r_value;
      w_state_nxt = r_state;
      w_lock_nxt  = r_lock_tmr;
      w_use_fast  = 1'b0;
`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
      w_gap_nxt    = (r_gap < FW_V) ? (r_gap + 1'b1) : r_gap;
      w_streak_nxt = r_streak;
      w_dir_nxt    = r_dir;
      w_quick      = 1'b0;
      // Idle for a full window drops back to slow steps.
      if ((r_state == ST_FAST) && (w_gap_nxt >= FW_V))
         w_state_nxt = ST_SLOW;
`endif

      // Lockout runs on time alone; the edge that sees 1 is the last locked one.
      if (r_state == ST_LOCK) begin
         if ((r_lock_tmr == '0) || (r_lock_tmr == LW'(1))) begin
            w_lock_nxt  = '0;
            w_state_nxt = ST_SLOW;
         end else begin
            w_lock_nxt = r_lock_tmr - 1'b1;
         end
      end

      if (bus.I_LOAD) begin
         w_value_nxt = f_sat(signed'({2'b00, bus.IV_LOAD}));
`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
         w_streak_nxt = '0;
         w_gap_nxt    = '0;
         // The gap timer restarts, so a pending FAST timeout is cancelled.
         if (r_state == ST_FAST)
            w_state_nxt = ST_FAST;
`endif
      end else if (bus.I_ERR) begin
         w_state_nxt = ST_LOCK;
         w_lock_nxt  = LOCK_V;
`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
         w_streak_nxt = '0;
`endif
      end else if (bus.I_CNT && (r_state != ST_LOCK)) begin
`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
         w_quick   = (r_gap < FW_V) && (bus.I_CW == r_dir);
         w_gap_nxt = '0;
         w_dir_nxt = bus.I_CW;
         if (!w_quick)
            w_streak_nxt = STW'(1);
         else if (r_streak < FC_V)
            w_streak_nxt = r_streak + 1'b1;
         // The detent that enters FAST, and a reversing one, still use SLOW_STEP.
         if (r_state == ST_FAST) begin
            if (w_quick) begin
               w_use_fast  = 1'b1;
               w_state_nxt = ST_FAST;
            end else begin
               w_state_nxt = ST_SLOW;
            end
         end else if (w_streak_nxt == FC_V) begin
            w_state_nxt = ST_FAST;
         end
`endif
         w_value_nxt = f_step(r_value, bus.I_CW, bus.I_WRAP, w_use_fast);
      end

      // The error count is diagnostic and counts every error pulse.
      if (bus.I_ERR_CLR)
         w_err_nxt = {3'b000, bus.I_ERR};
      else if (bus.I_ERR && (r_err_cnt != 4'hF))
         w_err_nxt = r_err_cnt + 4'd1;
      else
         w_err_nxt = r_err_cnt;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_value    <= INIT_V;
         r_changed  <= 1'b0;
         r_at_min   <= (INIT_V == MIN_V);
         r_at_max   <= (INIT_V == MAX_V);
         r_state    <= ST_SLOW;
         r_lock_tmr <= '0;
         r_err_cnt  <= 4'd0;
      end else begin
         r_value    <= w_value_nxt;
         r_changed  <= (w_value_nxt != r_value);
         r_at_min   <= (w_value_nxt == MIN_V);
         r_at_max   <= (w_value_nxt == MAX_V);
         r_state    <= w_state_nxt;
         r_lock_tmr <= w_lock_nxt;
         r_err_cnt  <= w_err_nxt;
      end
   end

`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_gap    <= '0;
         r_streak <= '0;
         r_dir    <= 1'b0;
      end else begin
         r_gap    <= w_gap_nxt;
         r_streak <= w_streak_nxt;
         r_dir    <= w_dir_nxt;
      end
   end

   assign bus.O_FAST = (r_state == ST_FAST);
`else
   assign bus.O_FAST = 1'b0;
`endif

   assign bus.OV_VALUE   = r_value;
   assign bus.O_CHANGED  = r_changed;
   assign bus.O_AT_MIN   = r_at_min;
   assign bus.O_AT_MAX   = r_at_max;
   assign bus.O_LOCKED   = (r_state == ST_LOCK);
   assign bus.OV_ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_rotary_value_ctrl.sv
// Testbench for rotary_value_ctrl. Stimulus pushes expected value changes and
// expected status snapshots into queues; a negedge monitor pops and compares.
module tb_rotary_value_ctrl;
   localparam int W = 8;
`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rotary_value_ctrl_if #(.WIDTH(W)) bus ();

   rotary_value_ctrl #(
      .WIDTH(W), .MIN(10), .MAX(20), .INIT(15), .SLOW_STEP(1), .FAST_STEP(4),
      .FAST_WINDOW(8), .FAST_COUNT(3), .LOCK_CYCLES(5)
   ) dut (
      .CLK(clk),
      .RST_N(rst_n),
      .bus(bus)
   );

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] chg_q[$];
   logic [15:0]  st_exp_q[$];
   string        st_name_q[$];
   logic [W-1:0] exp_val;
   bit           done     = 1'b0;
   bit           mon_done = 1'b0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model of the value: every real change must produce exactly one O_CHANGED.
   task automatic set_exp(input logic [W-1:0] v);
      if (v != exp_val) chg_q.push_back(v);
      exp_val = v;
   endtask

   task automatic chk(input string name, input logic f, input logic lk, input logic [3:0] e);
      st_name_q.push_back(name);
      st_exp_q.push_back({exp_val, (exp_val == 8'd10), (exp_val == 8'd20), f, lk, e});
   endtask

   task automatic step(input logic cw);
      bus.I_CNT = 1'b1;
      bus.I_CW  = cw;
      tick(1);
      bus.I_CNT = 1'b0;
   endtask

   task automatic load(input logic [W-1:0] v, input logic [W-1:0] expv);
      bus.I_LOAD  = 1'b1;
      bus.IV_LOAD = v;
      set_exp(expv);
      tick(1);
      bus.I_LOAD  = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      logic [15:0]  act;
      logic [15:0]  ex;
      logic [W-1:0] ev;
      string        nm;
      if (bus.O_CHANGED === 1'b1) begin
         n_checks++;
         if (chg_q.size() == 0) begin
            n_fail++;
            $display("FAIL changed_unexpected: O_CHANGED pulsed with OV_VALUE=%0d, required no pulse",
                     bus.OV_VALUE);
         end else begin
            ev = chg_q.pop_front();
            if (bus.OV_VALUE !== ev) begin
               n_fail++;
               $display("FAIL changed_value: OV_VALUE=%0d, required %0d", bus.OV_VALUE, ev);
            end
         end
      end
      while (st_exp_q.size() > 0) begin
         ex  = st_exp_q.pop_front();
         nm  = st_name_q.pop_front();
         act = {bus.OV_VALUE, bus.O_AT_MIN, bus.O_AT_MAX, bus.O_FAST, bus.O_LOCKED, bus.OV_ERR_CNT};
         n_checks++;
         if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got value=%0d min=%b max=%b fast=%b locked=%b err=%0d, required value=%0d min=%b max=%b fast=%b locked=%b err=%0d",
                     nm, act[15:8], act[7], act[6], act[5], act[4], act[3:0],
                     ex[15:8], ex[7], ex[6], ex[5], ex[4], ex[3:0]);
         end
      end
      if (done && !mon_done) begin
         n_checks++;
         if (chg_q.size() != 0) begin
            n_fail++;
            $display("FAIL changed_missing: %0d expected O_CHANGED pulses not seen, required 0", chg_q.size());
         end
         mon_done = 1'b1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      bus.I_CNT     = 1'b0;
      bus.I_CW      = 1'b0;
      bus.I_ERR     = 1'b0;
      bus.I_WRAP    = 1'b0;
      bus.I_LOAD    = 1'b0;
      bus.IV_LOAD   = '0;
      bus.I_ERR_CLR = 1'b0;
      exp_val       = 8'd15;
      tick(3);
      chk("reset", 1'b0, 1'b0, 4'd0);
      rst_n = 1'b1;

      // Saturating increments up to MAX, then one more that must not change.
      for (int k = 1; k <= 5; k++) begin
         tick(19);
         set_exp(W'(15 + k));
         step(1'b1);
         chk($sformatf("sat_up_%0d", k), 1'b0, 1'b0, 4'd0);
      end
      tick(19);
      step(1'b1);
      chk("sat_hold", 1'b0, 1'b0, 4'd0);

      // Wrap mode: 19 -> 20 -> 10.
      tick(2);
      load(8'd19, 8'd19);
      chk("load_19", 1'b0, 1'b0, 4'd0);
      bus.I_WRAP = 1'b1;
      tick(19);
      set_exp(8'd20);
      step(1'b1);
      chk("wrap_20", 1'b0, 1'b0, 4'd0);
      tick(19);
      set_exp(8'd10);
      step(1'b1);
      chk("wrap_10", 1'b0, 1'b0, 4'd0);
      bus.I_WRAP = 1'b0;

      // Quick detents every 4 cycles, then idle through the window.
      tick(19);
      set_exp(8'd11);
      step(1'b1);
      chk("accel_1", 1'b0, 1'b0, 4'd0);
      tick(3);
      set_exp(8'd12);
      step(1'b1);
      chk("accel_2", 1'b0, 1'b0, 4'd0);
      tick(3);
      set_exp(8'd13);
      step(1'b1);
      chk("accel_3_enter", ACCEL, 1'b0, 4'd0);
      tick(3);
      set_exp(ACCEL ? 8'd17 : 8'd14);
      step(1'b1);
      chk("accel_4_fast", ACCEL, 1'b0, 4'd0);
      tick(7);
      chk("fast_hold", ACCEL, 1'b0, 4'd0);
      tick(1);
      chk("fast_timeout", 1'b0, 1'b0, 4'd0);
      tick(3);
      set_exp(ACCEL ? 8'd18 : 8'd15);
      step(1'b1);
      chk("accel_5_slow", 1'b0, 1'b0, 4'd0);

      // Error together with a detent, lockout window and its exit.
      tick(19);
      load(8'd15, 8'd15);
      chk("pre_err", 1'b0, 1'b0, 4'd0);
      bus.I_ERR = 1'b1;
      bus.I_CNT = 1'b1;
      bus.I_CW  = 1'b1;
      tick(1);
      bus.I_ERR = 1'b0;
      bus.I_CNT = 1'b0;
      chk("err_with_cnt", 1'b0, 1'b1, 4'd1);
      tick(1);
      step(1'b1);
      chk("lock_ignore", 1'b0, 1'b1, 4'd1);
      tick(2);
      chk("lock_last", 1'b0, 1'b1, 4'd1);
      step(1'b1);
      chk("lock_exit", 1'b0, 1'b0, 4'd1);
      tick(3);
      set_exp(8'd16);
      step(1'b1);
      chk("post_lock", 1'b0, 1'b0, 4'd1);

      // Load beats a concurrent detent and is clamped at both ends.
      tick(2);
      bus.I_CNT = 1'b1;
      bus.I_CW  = 1'b0;
      load(8'd30, 8'd20);
      bus.I_CNT = 1'b0;
      chk("load_clamp_hi", 1'b0, 1'b0, 4'd1);
      tick(2);
      load(8'd3, 8'd10);
      chk("load_clamp_lo", 1'b0, 1'b0, 4'd1);

      // Error counter: clear, saturate, clear with simultaneous error.
      tick(2);
      bus.I_ERR_CLR = 1'b1;
      tick(1);
      bus.I_ERR_CLR = 1'b0;
      chk("err_clr", 1'b0, 1'b0, 4'd0);
      for (int i = 1; i <= 17; i++) begin
         bus.I_ERR = 1'b1;
         tick(1);
         bus.I_ERR = 1'b0;
         if (i == 14) chk("err_cnt_14", 1'b0, 1'b1, 4'd14);
         tick(1);
      end
      chk("err_cnt_sat", 1'b0, 1'b1, 4'd15);
      bus.I_ERR     = 1'b1;
      bus.I_ERR_CLR = 1'b1;
      tick(1);
      bus.I_ERR     = 1'b0;
      bus.I_ERR_CLR = 1'b0;
      chk("err_clr_with_err", 1'b0, 1'b1, 4'd1);
      tick(4);
      chk("relock_hold", 1'b0, 1'b1, 4'd1);
      tick(1);
      chk("relock_exit", 1'b0, 1'b0, 4'd1);

      tick(2);
      done = 1'b1;
      wait (mon_done);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rotary_value_ctrl.md
Name: rotary_value_ctrl

Overview:
- Controller between the quadrature decoder's count/direction/error pulses and the display value register.
- Owns the user-visible value: applies bounded or wrapping arithmetic, speed-dependent step size (acceleration) and post-error lockout.
- Drives the 7-segment digit decoders and status LEDs directly; replaces ad-hoc +1/-1 logic in tops.

Parameters:
- WIDTH, 8, bit width of value.
- MIN, 0, lower bound (inclusive).
- MAX, 255, upper bound (inclusive). Requires MIN < MAX < 2^WIDTH.
- INIT, 0, value after reset. Clamped to [MIN,MAX].
- SLOW_STEP, 1, step per detent in SLOW.
- FAST_STEP, 4, step per detent in FAST.
- FAST_WINDOW, 250000, max cycles between detents that count as "quick".
- FAST_COUNT, 3, consecutive quick same-direction detents needed to enter FAST.
- LOCK_CYCLES, 125000, cycles of input lockout after an error pulse.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous reset, active low.
- I_CNT  in  1  one-cycle detent pulse from the decoder.
- I_CW  in  1  direction, qualified by I_CNT (1 = increment).
- I_ERR  in  1  one-cycle decode-error pulse.
- I_WRAP  in  1  1 = wrap at bounds, 0 = saturate. Sampled per step.
- I_LOAD  in  1  one-cycle load strobe.
- IV_LOAD  in  WIDTH  load value.
- I_ERR_CLR  in  1  clears the error counter.
- OV_VALUE  out  WIDTH  current value.
- O_CHANGED  out  1  one-cycle pulse whenever OV_VALUE changes.
- O_AT_MIN  out  1  OV_VALUE == MIN.
- O_AT_MAX  out  1  OV_VALUE == MAX.
- O_FAST  out  1  FSM in FAST.
- O_LOCKED  out  1  FSM in LOCK.
- OV_ERR_CNT  out  4  saturating error count.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - OV_VALUE = INIT clamped; state = SLOW.
  - Streak, gap timer, lock timer and OV_ERR_CNT = 0.
  - O_CHANGED = 0, O_FAST = 0, O_LOCKED = 0.
  - O_AT_MIN/O_AT_MAX reflect INIT.
  - Reset mid-lock or mid-FAST aborts immediately.
- All outputs registered. A step accepted at edge N is visible on OV_VALUE after edge N. O_CHANGED is high for the following cycle only, and only if the value actually differs (a saturated step gives no pulse).
- Priority per cycle: RST_N > I_LOAD > I_ERR > I_CNT.
  - I_LOAD: OV_VALUE = IV_LOAD clamped to [MIN,MAX]. Streak = 0, gap timer reset, state unchanged. Concurrent I_CNT is discarded.
  - I_ERR with I_CNT in the same cycle: the step is discarded and the error is handled.
- Step arithmetic:
  - Step size S = SLOW_STEP or FAST_STEP per current state.
  - Computed in WIDTH+2 signed bits; no intermediate overflow.
  - Saturate mode: result clamped to MIN/MAX.
  - Wrap mode: result reduced modulo (MAX-MIN+1) into [MIN,MAX]. Example: MAX = 255, CW, S = 4, value 254 -> MIN+2.
- Gap timer:
  - Counts cycles since the last accepted detent; saturates at FAST_WINDOW.
  - A detent is "quick" if the timer < FAST_WINDOW and I_CW equals the previous direction.
  - Quick detent: streak += 1, saturating at FAST_COUNT. Otherwise streak = 1.
  - Timer resets to 0 on every accepted detent.
- FSM states: SLOW, FAST, LOCK.
  - SLOW -> FAST: when an accepted detent brings streak to FAST_COUNT. That detent still uses SLOW_STEP.
  - FAST -> SLOW: gap timer reaches FAST_WINDOW, or an accepted detent has the opposite direction. The reversing detent uses SLOW_STEP.
  - SLOW/FAST -> LOCK: on I_ERR. Lock timer = LOCK_CYCLES, streak = 0.
  - LOCK: I_CNT ignored. A further I_ERR reloads the lock timer. I_LOAD is still honoured.
  - LOCK -> SLOW: when the lock timer reaches 0.
- OV_ERR_CNT: +1 per I_ERR, saturates at 15. I_ERR_CLR zeroes it; if I_ERR_CLR and I_ERR occur in the same cycle, the result is 1.

Optional Feature:
- Macro: ROTARY_VALUE_CTRL_ACCEL_EN.
- Defined: acceleration as described.
- Undefined:
  - Streak logic, gap timer and FAST state are not built.
  - Step is always SLOW_STEP; O_FAST is tied 0.
  - FSM has SLOW and LOCK only.
  - All other behaviour is identical.

Test Plan:
- Bench parameters: MIN = 10, MAX = 20, INIT = 15, FAST_WINDOW = 8, FAST_COUNT = 3, LOCK_CYCLES = 5, WRAP = 0.
- Reset then 5 CW pulses 20 cycles apart -> OV_VALUE 16..20, O_AT_MAX = 1. A 6th pulse -> stays 20, no O_CHANGED.
- WRAP = 1, value 19, SLOW: 2 CW pulses spaced 20 cycles -> 20 then 10; O_AT_MIN = 1 after the second.
- ACCEL_EN defined, value 10: CW pulses every 4 cycles -> 11, 12, 13 (FAST entered, O_FAST = 1), 17. Idle 8 cycles -> O_FAST = 0. Next pulse -> 18.
- I_ERR with I_CNT in the same cycle at value 15 -> value stays 15, O_LOCKED = 1 for 5 cycles, OV_ERR_CNT = 1. Pulses inside the window are ignored; the first pulse after lock -> 16.
- I_LOAD = 30 with CCW I_CNT in the same cycle -> OV_VALUE = 20 (clamped), one O_CHANGED pulse.
- 17 I_ERR pulses -> OV_ERR_CNT = 15. I_ERR_CLR with I_ERR in the same cycle -> OV_ERR_CNT = 1.
